// File: rtl/kbd_event_arb_pkg.sv
// kbd_pkg: shared key-arbiter defaults for the one-shot array, arbiter and consumers
// Contents: N_KEYS, KW (key index width), DEPTH (event FIFO entries), key_idx_t
package kbd_pkg;
  localparam int N_KEYS = 4;
  localparam int KW = 2;
  localparam int DEPTH = 4;
  typedef logic [KW-1:0] key_idx_t;
endpackage

// File: rtl/kbd_event_arb_if.sv
// kbd_event_arb_if: key event stream handshake between arbiter and consumer
// Signals: ev_valid (head holds an event), ev_key (head key index), ev_ready (consumer accepts head)
interface kbd_event_arb_if #(parameter int KW = kbd_pkg::KW);
  logic ev_valid;
  logic [KW-1:0] ev_key;
  logic ev_ready;
  modport master(output ev_valid, ev_key, input ev_ready);
  modport slave(input ev_valid, ev_key, output ev_ready);
endinterface

// File: rtl/kbd_event_arb_fifo.sv
// kbd_event_fifo: DEPTH x W first-word-fall-through FIFO with occupancy count
// Ports: clk, rst (sync, active-high), push_i/din_i write, pop_i read, dout_o = head,
//        full_o/empty_o status, level_o entry count
module kbd_event_fifo #(
  parameter int DEPTH = kbd_pkg::DEPTH,
  parameter int W = kbd_pkg::KW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  assign dout_o = mem_q[rd_q];
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  // Pointers wrap naturally; when full, push and pop hit the same slot and the head is read before it is overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i) level_q <= level_q + 1'b1;
      else if (pop_i && !push_i) level_q <= level_q - 1'b1;
    end
  end
endmodule

// File: rtl/kbd_event_arb.sv
// kbd_event_arb: merges per-key press pulses into one round-robin ordered event stream
// Ports: clk, rst (sync, active-high), key_pulse one-cycle presses, ev (master: ev_valid/ev_key out, ev_ready in),
//        ovf sticky lost-press flag, ovf_clr clears it, level FIFO occupancy
module kbd_event_arb #(
  parameter int N_KEYS = kbd_pkg::N_KEYS,
  parameter int KW = kbd_pkg::KW,
  parameter int DEPTH = kbd_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_KEYS-1:0]      key_pulse,
  kbd_event_arb_if.master        ev,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] level
);
  logic [N_KEYS-1:0] pending_q, pending_d, gnt_oh;
  logic [KW-1:0] last_q, last_d, gnt_idx, idx;
  logic gnt_any, grant, pop, push_ok, full, empty, ovf_q, ovf_d, coalesce;
  assign ev.ev_valid = !empty;
  assign pop = ev.ev_valid && ev.ev_ready;
  assign push_ok = !full || pop;
  // Scan offsets from far to near so the nearest pending key after last_q wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = N_KEYS; k >= 1; k--) begin
      idx = KW'((int'(last_q) + k) % N_KEYS);
      if (pending_q[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign grant = gnt_any && push_ok;
  assign gnt_oh = grant ? {{(N_KEYS-1){1'b0}}, 1'b1} << gnt_idx : '0;
  // A pulse on the key being granted re-arms its latch rather than counting as a lost press
  assign pending_d = (pending_q & ~gnt_oh) | key_pulse;
  assign coalesce = |(key_pulse & pending_q & ~gnt_oh);
  assign ovf_d = coalesce || (ovf_q && !ovf_clr);
  assign last_d = grant ? gnt_idx : last_q;
  assign ovf = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      last_q <= KW'(N_KEYS-1);
      ovf_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
    end
  end
  kbd_event_fifo #(.DEPTH(DEPTH), .W(KW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(grant),
    .din_i(gnt_idx),
    .pop_i(pop),
    .dout_o(ev.ev_key),
    .full_o(full),
    .empty_o(empty),
    .level_o(level)
  );
endmodule
